// File: rtl/dpram_pkg.sv
// Shared constants, FSM state type and saturating-increment helper for the
// dual-port RAM front-end arbiter.
package dpram_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 4;
  localparam int CCNT_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [CCNT_W-1:0] sat_inc(input logic [CCNT_W-1:0] v);
    return (v == {CCNT_W{1'b1}}) ? v : v + CCNT_W'(1);
  endfunction

endpackage

// File: rtl/dpram_arb_core.sv
// Conflict detection and grant selection; purely combinational, zero latency.
// A same-address access pair involving a write grants only the prio side.
module dpram_arb_core
  import dpram_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          i_en,
  input  logic          i_prio,
  input  logic          i_a_req,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic          i_b_req,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  output logic          o_a_gnt,
  output logic          o_b_gnt,
  output logic          o_conflict
);

  logic w_conflict;

  always_comb begin
    // read-read to one address is safe on a true dual-port RAM
    w_conflict = i_a_req & i_b_req & (i_a_addr == i_b_addr) & (i_a_we | i_b_we);
    o_conflict = i_en & w_conflict;
    o_a_gnt    = i_en & i_a_req & (~w_conflict | ~i_prio);
    o_b_gnt    = i_en & i_b_req & (~w_conflict |  i_prio);
  end

endmodule

// File: rtl/raminfr.sv
// 2^AW x DW true dual-port RAM, synchronous read-first ports, no reset.
// Both write ports are sampled on clk1; in this system clk1 and clk2 are tied.
module raminfr #(
  parameter int AW = 5,
  parameter int DW = 4
) (
  input  logic          clk1,
  input  logic          clk2,
  input  logic          wea,
  input  logic          web,
  input  logic [AW-1:0] addra,
  input  logic [AW-1:0] addrb,
  input  logic [DW-1:0] dia,
  input  logic [DW-1:0] dib,
  output logic [DW-1:0] doa,
  output logic [DW-1:0] dob
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk1) begin
    if (wea) r_mem[addra] <= dia;
    if (web) r_mem[addrb] <= dib;
    doa <= r_mem[addra];
  end

  always_ff @(posedge clk2) begin
    dob <= r_mem[addrb];
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Front-end for raminfr: clears the RAM after reset, then arbitrates A/B requesters.
// Grant is same-cycle, RAM command at +1, read data/valid at +2; requesters hold until granted.
module dpram_arbiter
  import dpram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [DW-1:0]     a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AW-1:0]     b_addr,
  input  logic [DW-1:0]     b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DW-1:0]     a_rdata,
  output logic [DW-1:0]     b_rdata,
  output logic              init_done,
  output logic [CCNT_W-1:0] conflict_cnt,
  output logic              ram_wea,
  output logic              ram_web,
  output logic [AW-1:0]     ram_addra,
  output logic [AW-1:0]     ram_addrb,
  output logic [DW-1:0]     ram_dia,
  output logic [DW-1:0]     ram_dib,
  input  logic [DW-1:0]     ram_doa,
  input  logic [DW-1:0]     ram_dob
);

  localparam int ICW = (AW > 1) ? AW - 1 : 1;
  localparam logic [ICW-1:0] ICNT_LAST = ICW'((1 << (AW - 1)) - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ICW-1:0]    r_icnt;
  logic [ICW-1:0]    w_icnt_nxt;
  logic              r_prio;
  logic [CCNT_W-1:0] r_ccnt;
  logic              r_wea;
  logic              r_web;
  logic [AW-1:0]     r_addra;
  logic [AW-1:0]     r_addrb;
  logic [DW-1:0]     r_dia;
  logic [DW-1:0]     r_dib;
  logic              r_a_rv1;
  logic              r_a_rv2;
  logic              r_b_rv1;
  logic              r_b_rv2;
  logic              w_run;
  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_conflict;
  logic [AW-1:0]     w_init_addra;
  logic [AW-1:0]     w_init_addrb;

  assign w_run = (r_state == RUN);

  // each INIT cycle clears an even/odd address pair
  assign w_init_addra = AW'({r_icnt, 1'b0});
  assign w_init_addrb = w_init_addra | AW'(1);

  dpram_arb_core #(
    .AW (AW)
  ) u_core (
    .i_en       (w_run),
    .i_prio     (r_prio),
    .i_a_req    (a_req),
    .i_a_we     (a_we),
    .i_a_addr   (a_addr),
    .i_b_req    (b_req),
    .i_b_we     (b_we),
    .i_b_addr   (b_addr),
    .o_a_gnt    (w_a_gnt),
    .o_b_gnt    (w_b_gnt),
    .o_conflict (w_conflict)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_icnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_icnt  <= w_icnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_icnt_nxt  = r_icnt;
    case (r_state)
      INIT: begin
        if (r_icnt == ICNT_LAST) begin
          w_state_nxt = RUN;
          w_icnt_nxt  = '0;
        end else begin
          w_icnt_nxt = r_icnt + ICW'(1);
        end
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = INIT;
    endcase
  end

  // prio always flips to the side that just lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
      r_ccnt <= '0;
    end else if (w_conflict) begin
      r_prio <= ~r_prio;
      r_ccnt <= sat_inc(r_ccnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wea   <= 1'b0;
      r_web   <= 1'b0;
      r_addra <= '0;
      r_addrb <= '0;
      r_dia   <= '0;
      r_dib   <= '0;
    end else if (!w_run) begin
      r_wea   <= 1'b1;
      r_web   <= 1'b1;
      r_addra <= w_init_addra;
      r_addrb <= w_init_addrb;
      r_dia   <= '0;
      r_dib   <= '0;
    end else begin
      r_wea <= w_a_gnt & a_we;
      r_web <= w_b_gnt & b_we;
      if (w_a_gnt) r_addra <= a_addr;
      if (w_b_gnt) r_addrb <= b_addr;
      if (w_a_gnt && a_we) r_dia <= a_wdata;
      if (w_b_gnt && b_we) r_dib <= b_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rv1 <= 1'b0;
      r_a_rv2 <= 1'b0;
      r_b_rv1 <= 1'b0;
      r_b_rv2 <= 1'b0;
    end else begin
      r_a_rv1 <= w_a_gnt & ~a_we;
      r_a_rv2 <= r_a_rv1;
      r_b_rv1 <= w_b_gnt & ~b_we;
      r_b_rv2 <= r_b_rv1;
    end
  end

  assign a_gnt        = w_a_gnt;
  assign b_gnt        = w_b_gnt;
  assign a_rvalid     = r_a_rv2;
  assign b_rvalid     = r_b_rv2;
  assign a_rdata      = r_a_rv2 ? ram_doa : '0;
  assign b_rdata      = r_b_rv2 ? ram_dob : '0;
  assign init_done    = w_run;
  assign conflict_cnt = r_ccnt;
  assign ram_wea      = r_wea;
  assign ram_web      = r_web;
  assign ram_addra    = r_addra;
  assign ram_addrb    = r_addrb;
  assign ram_dia      = r_dia;
  assign ram_dib      = r_dib;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter + raminfr: per-cycle comparison against a behavioural
// model (memory array, prio bit, counters) plus directed literal checks.
module tb_dpram_arbiter;
  import dpram_pkg::*;

  localparam int AW       = AW_DEF;
  localparam int DW       = DW_DEF;
  localparam int DEPTH    = 1 << AW;
  localparam int INIT_CYC = DEPTH / 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_req, a_we, b_req, b_we;
  logic [AW-1:0]     a_addr, b_addr;
  logic [DW-1:0]     a_wdata, b_wdata;
  logic              a_gnt, b_gnt, a_rvalid, b_rvalid, init_done;
  logic [DW-1:0]     a_rdata, b_rdata;
  logic [CCNT_W-1:0] conflict_cnt;
  logic              ram_wea, ram_web;
  logic [AW-1:0]     ram_addra, ram_addrb;
  logic [DW-1:0]     ram_dia, ram_dib, ram_doa, ram_dob;

  always #5 clk = ~clk;

  dpram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .init_done(init_done),
    .conflict_cnt(conflict_cnt),
    .ram_wea(ram_wea), .ram_web(ram_web), .ram_addra(ram_addra), .ram_addrb(ram_addrb),
    .ram_dia(ram_dia), .ram_dib(ram_dib), .ram_doa(ram_doa), .ram_dob(ram_dob)
  );

  raminfr #(.AW(AW), .DW(DW)) u_ram (
    .clk1(clk), .clk2(clk), .wea(ram_wea), .web(ram_web),
    .addra(ram_addra), .addrb(ram_addrb), .dia(ram_dia), .dib(ram_dib),
    .doa(ram_doa), .dob(ram_dob)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            cyc;
  bit            m_prio;
  int            m_cnt;
  logic [DW-1:0] m_mem [DEPTH];
  bit            pa_v [4];
  bit            pb_v [4];
  logic [DW-1:0] pa_d [4];
  logic [DW-1:0] pb_d [4];
  bit            c_we_a, c_we_b;
  logic [AW-1:0] c_addr_a, c_addr_b;
  logic [DW-1:0] c_d_a, c_d_b;

  task automatic model_reset();
    cyc = 0; m_prio = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int i = 0; i < 4; i++) begin pa_v[i] = 0; pb_v[i] = 0; pa_d[i] = '0; pb_d[i] = '0; end
    c_we_a = 0; c_we_b = 0; c_addr_a = '0; c_addr_b = '0; c_d_a = '0; c_d_b = '0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("rst_init_done", init_done, 0);
      check("rst_gnt", {a_gnt, b_gnt}, 0);
      check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
      check("rst_rdata", {a_rdata, b_rdata}, 0);
      check("rst_cnt", conflict_cnt, 0);
      check("rst_ram_we", {ram_wea, ram_web}, 0);
      check("rst_ram_addr", {ram_addra, ram_addrb}, 0);
      check("rst_ram_di", {ram_dia, ram_dib}, 0);
      model_reset();
    end else begin : step
      bit run, conf, ga, gb;
      int s;
      run  = (cyc >= INIT_CYC);
      conf = run && a_req && b_req && (a_addr == b_addr) && (a_we || b_we);
      ga   = run && a_req && (!conf || !m_prio);
      gb   = run && b_req && (!conf ||  m_prio);
      check("init_done", init_done, run);
      check("a_gnt", a_gnt, ga);
      check("b_gnt", b_gnt, gb);
      check("conflict_cnt", conflict_cnt, m_cnt);
      s = cyc % 4;
      check("a_rvalid", a_rvalid, pa_v[s]);
      check("a_rdata", a_rdata, pa_v[s] ? pa_d[s] : '0);
      check("b_rvalid", b_rvalid, pb_v[s]);
      check("b_rdata", b_rdata, pb_v[s] ? pb_d[s] : '0);
      pa_v[s] = 0; pb_v[s] = 0;
      check("ram_wea", ram_wea, c_we_a);
      check("ram_web", ram_web, c_we_b);
      check("ram_addra", ram_addra, c_addr_a);
      check("ram_addrb", ram_addrb, c_addr_b);
      if (c_we_a) check("ram_dia", ram_dia, c_d_a);
      if (c_we_b) check("ram_dib", ram_dib, c_d_b);
      if (conf) begin
        m_prio = !m_prio;
        if (m_cnt < 255) m_cnt++;
      end
      if (!run) begin
        c_we_a = 1; c_we_b = 1;
        c_addr_a = AW'(2 * cyc); c_addr_b = AW'(2 * cyc + 1);
        c_d_a = '0; c_d_b = '0;
      end else begin
        c_we_a = ga && a_we;
        c_we_b = gb && b_we;
        if (ga) c_addr_a = a_addr;
        if (gb) c_addr_b = b_addr;
        if (ga && a_we) c_d_a = a_wdata;
        if (gb && b_we) c_d_b = b_wdata;
        if (ga && !a_we) begin pa_v[(cyc + 2) % 4] = 1; pa_d[(cyc + 2) % 4] = m_mem[a_addr]; end
        if (gb && !b_we) begin pb_v[(cyc + 2) % 4] = 1; pb_d[(cyc + 2) % 4] = m_mem[b_addr]; end
        if (ga && a_we) m_mem[a_addr] = a_wdata;
        if (gb && b_we) m_mem[b_addr] = b_wdata;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd2(input int aa, input int ae, input int ba, input int be);
    tick();
    a_req = 1; a_we = 0; a_addr = AW'(aa);
    b_req = 1; b_we = 0; b_addr = AW'(ba);
    @(negedge clk);
    check("rd2_gnt", {a_gnt, b_gnt}, 2'b11);
    tick();
    a_req = 0; b_req = 0;
    @(negedge clk);
    @(negedge clk);
    check("rd2_a_rvalid", a_rvalid, 1);
    check("rd2_a_rdata", a_rdata, ae);
    check("rd2_b_rvalid", b_rvalid, 1);
    check("rd2_b_rdata", b_rdata, be);
  endtask

  task automatic wr2(input int aa, input int ad, input int ba, input int bd);
    tick();
    a_req = 1; a_we = 1; a_addr = AW'(aa); a_wdata = DW'(ad);
    b_req = 1; b_we = 1; b_addr = AW'(ba); b_wdata = DW'(bd);
    @(negedge clk);
    check("wr2_gnt", {a_gnt, b_gnt}, 2'b11);
    tick();
    a_req = 0; b_req = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit a_took, b_took;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    rst = 0;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    repeat (16) @(negedge clk);
    check("init_done_c15", init_done, 0);
    @(negedge clk);
    check("init_done_c16", init_done, 1);
    repeat (3) @(negedge clk);

    rd2(0, 0, 1, 0);
    rd2(30, 0, 31, 0);

    wr2(6, 'hA, 7, 'hB);
    rd2(6, 'hA, 7, 'hB);

    // same-address write conflict: A first (prio 0), B one cycle later
    tick();
    a_req = 1; a_we = 1; a_addr = 6; a_wdata = 'hA;
    b_req = 1; b_we = 1; b_addr = 6; b_wdata = 'hB;
    @(negedge clk);
    check("conf1_gnt", {a_gnt, b_gnt}, 2'b10);
    tick();
    a_req = 0;
    @(negedge clk);
    check("conf1_b_late", b_gnt, 1);
    tick();
    b_req = 0;
    @(negedge clk);
    check("conf1_cnt", conflict_cnt, 1);
    rd2(6, 'hB, 6, 'hB);

    // prio now 1: B write beats A read; A then reads the new value
    tick();
    a_req = 1; a_we = 0; a_addr = 3;
    b_req = 1; b_we = 1; b_addr = 3; b_wdata = 'h5;
    @(negedge clk);
    check("conf2_gnt", {a_gnt, b_gnt}, 2'b01);
    tick();
    b_req = 0;
    @(negedge clk);
    check("conf2_a_late", a_gnt, 1);
    tick();
    a_req = 0;
    @(negedge clk);
    @(negedge clk);
    check("conf2_rdata", a_rdata, 'h5);
    check("conf2_cnt", conflict_cnt, 2);

    wr2(9, 'h7, 10, 'h3);
    rd2(9, 'h7, 9, 'h7);
    check("rr_cnt", conflict_cnt, 2);

    // write then read of the same address on back-to-back grants
    tick();
    a_req = 1; a_we = 1; a_addr = 12; a_wdata = 'hC;
    @(negedge clk);
    tick();
    a_we = 0;
    @(negedge clk);
    check("wr_rd_gnt", a_gnt, 1);
    tick();
    a_req = 0;
    @(negedge clk);
    @(negedge clk);
    check("wr_rd_data", a_rdata, 'hC);

    // sustained conflict: strict alternation, counter saturates
    tick();
    a_req = 1; a_we = 1; a_addr = 5; a_wdata = 'h1;
    b_req = 1; b_we = 1; b_addr = 5; b_wdata = 'h2;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check("alt_gnt", {a_gnt, b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    tick();
    a_req = 0; b_req = 0;
    @(negedge clk);
    check("sat_cnt", conflict_cnt, 255);

    a_took = 0; b_took = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (!a_req || a_took || $urandom_range(9) == 0) begin
        a_req = ($urandom_range(2) != 0); a_we = 1'($urandom_range(1));
        a_addr = AW'($urandom_range(7)); a_wdata = DW'($urandom);
      end
      if (!b_req || b_took || $urandom_range(9) == 0) begin
        b_req = ($urandom_range(2) != 0); b_we = 1'($urandom_range(1));
        b_addr = AW'($urandom_range(7)); b_wdata = DW'($urandom);
      end
      @(negedge clk);
      a_took = a_gnt; b_took = b_gnt;
    end
    tick();
    a_req = 0; b_req = 0;

    // reset with a B read in flight; RAM must be cleared again
    wr2(6, 'hF, 7, 'hE);
    tick();
    b_req = 1; b_we = 0; b_addr = 6;
    @(negedge clk);
    check("inflight_gnt", b_gnt, 1);
    tick();
    b_req = 0;
    rst = 1;
    @(negedge clk);
    check("inflight_rvalid", b_rvalid, 0);
    tick();
    tick();
    rst = 0;
    repeat (17) @(negedge clk);
    check("reinit_done", init_done, 1);
    check("reinit_cnt", conflict_cnt, 0);
    rd2(6, 0, 7, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
